// File: rtl/seq_pattern_gen.sv
// Serial test-pattern transmitter: steps a latched WIDTH-bit pattern out MSB-first on x,
// one bit per key press. Define SEQ_DEBOUNCE_EN to insert a counter-based key filter.
module seq_pattern_gen #(
    parameter int WIDTH  = 8,
    parameter int IDX_W  = 3,
    parameter int DB_CNT = 500000,
    parameter int DB_W   = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             anjian,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic             loop,
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] bit_idx
);

    if (WIDTH < 2 || WIDTH > 16 || (2 ** IDX_W) < WIDTH) begin : g_bad_width
        $error("seq_pattern_gen: WIDTH must be 2..16 and fit in IDX_W bits");
    end
    if (DB_W < 1 || DB_CNT < 1 || DB_CNT > (2 ** DB_W)) begin : g_bad_db
        $error("seq_pattern_gen: DB_CNT must be 1..2**DB_W");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic key_s1_q;
    logic key_s2_q;
    logic key_lvl;
    logic key_prev_q;
    logic step_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1_q   <= 1'b0;
            key_s2_q   <= 1'b0;
            key_prev_q <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            key_s1_q   <= anjian;
            key_s2_q   <= key_s1_q;
            key_prev_q <= key_lvl;
            step_q     <= key_lvl & ~key_prev_q;
        end
    end

`ifdef SEQ_DEBOUNCE_EN
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            db_lvl_q;
    logic            db_lvl_d;

    // The filtered level flips on the DB_CNT-th consecutive differing sample.
    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        if (key_s2_q != db_lvl_q) begin
            if (db_cnt_q == DB_W'(DB_CNT - 1)) begin
                db_lvl_d = key_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
        end
    end

    assign key_lvl = db_lvl_q;
`else
    assign key_lvl = key_s2_q;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-2:0] sh_q, sh_d;
    logic             loop_q, loop_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;

    // sh_q holds the bits still to be sent after the one currently on x.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        sh_d      = sh_q;
        loop_d    = loop_q;
        x_d       = x_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bit_idx_d = bit_idx_q;
        unique case (state_q)
            IDLE: begin
                x_d       = 1'b0;
                busy_d    = 1'b0;
                bit_idx_d = '0;
                if (start) begin
                    pat_d   = pattern;
                    loop_d  = loop;
                    sh_d    = pattern[WIDTH-2:0];
                    x_d     = pattern[WIDTH-1];
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (step_q) begin
                    if (bit_idx_q != LAST_IDX) begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        x_d       = sh_q[WIDTH-2];
                        sh_d      = sh_q << 1;
                    end else if (loop_q) begin
                        bit_idx_d = '0;
                        x_d       = pat_q[WIDTH-1];
                        sh_d      = pat_q[WIDTH-2:0];
                        done_d    = 1'b1;
                    end else begin
                        bit_idx_d = '0;
                        x_d       = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                x_d     = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                x_d       = 1'b0;
                busy_d    = 1'b0;
                bit_idx_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            sh_q      <= '0;
            loop_q    <= 1'b0;
            x_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            sh_q      <= sh_d;
            loop_q    <= loop_d;
            x_q       <= x_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign x       = x_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed self-checking bench for seq_pattern_gen: reset, shifting, loop mode,
// ignored start, mid-run reset and (with SEQ_DEBOUNCE_EN) the key filter.
module tb_seq_pattern_gen;

`ifdef SEQ_DEBOUNCE_EN
    localparam int HOLD = 24;
`else
    localparam int HOLD = 4;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       anjian;
    logic       start;
    logic [7:0] pattern;
    logic       loop;
    logic       x;
    logic       busy;
    logic       done;
    logic [2:0] bit_idx;

    int n_checks = 0;
    int n_errors = 0;

    seq_pattern_gen #(
        .WIDTH (8),
        .IDX_W (3),
        .DB_CNT(16),
        .DB_W  (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .anjian (anjian),
        .start  (start),
        .pattern(pattern),
        .loop   (loop),
        .x      (x),
        .busy   (busy),
        .done   (done),
        .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clean key press; counts done pulses and busy levels over its window.
    task automatic press(output int dones, output int busy_lo, output int busy_hi);
        dones = 0; busy_lo = 0; busy_hi = 0;
        anjian = 1'b1;
        for (int i = 0; i < 2 * HOLD; i++) begin
            if (i == HOLD) anjian = 1'b0;
            tick();
            if (done) dones++;
            if (busy) busy_hi++; else busy_lo++;
        end
    endtask

    task automatic do_start(input logic [7:0] p, input logic lp);
        pattern = p; loop = lp; start = 1'b1;
        tick();
        start = 1'b0; pattern = 8'h00; loop = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int d, bl, bh, dsum;
        do_reset(2);
        n_checks++;
        if ({x, busy, done, bit_idx} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_state: got x=%b busy=%b done=%b idx=%0d expected all 0", x, busy, done, bit_idx);
        end
        dsum = 0;
        for (int k = 0; k < 5; k++) begin
            press(d, bl, bh);
            dsum += d + bh;
        end
        n_checks++;
        if ({x, busy, done, bit_idx} !== 6'b0 || dsum != 0) begin
            n_errors++;
            $display("FAIL idle_steps: got x=%b busy=%b idx=%0d done/busy cycles=%0d expected idle, 0", x, busy, bit_idx, dsum);
        end
    endtask

    task automatic test_basic_shift();
        logic [7:0] p;
        int d, bl, bh;
        p = 8'b1011_0010;
        do_start(p, 1'b0);
        n_checks++;
        if (x !== 1'b1 || busy !== 1'b1 || bit_idx !== 3'd0) begin
            n_errors++;
            $display("FAIL shift_start: got x=%b busy=%b idx=%0d expected 1 1 0", x, busy, bit_idx);
        end
        for (int s = 1; s < 8; s++) begin
            press(d, bl, bh);
            n_checks++;
            if (x !== p[7-s] || bit_idx !== 3'(s) || busy !== 1'b1 || d != 0) begin
                n_errors++;
                $display("FAIL shift_step%0d: got x=%b idx=%0d busy=%b done=%0d expected x=%b idx=%0d busy=1 done=0",
                         s, x, bit_idx, busy, d, p[7-s], s);
            end
        end
        press(d, bl, bh);
        n_checks++;
        if (d != 1 || x !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL shift_end: got done_cycles=%0d x=%b busy=%b expected 1 0 0", d, x, busy);
        end
    endtask

    task automatic test_loop();
        logic [7:0] p;
        int d, bl, bh, exp_d;
        p = 8'hA5;
        do_start(p, 1'b1);
        n_checks++;
        if (x !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL loop_start: got x=%b busy=%b expected 1 1", x, busy);
        end
        for (int s = 1; s <= 16; s++) begin
            press(d, bl, bh);
            exp_d = (s % 8 == 0) ? 1 : 0;
            n_checks++;
            if (x !== p[7-(s%8)] || bit_idx !== 3'(s % 8) || d != exp_d || bl != 0) begin
                n_errors++;
                $display("FAIL loop_step%0d: got x=%b idx=%0d done=%0d busy_low=%0d expected x=%b idx=%0d done=%0d busy_low=0",
                         s, x, bit_idx, d, bl, p[7-(s%8)], s % 8, exp_d);
            end
        end
        do_reset(1);
    endtask

    task automatic test_ignored_start();
        logic [7:0] p;
        int d, bl, bh;
        p = 8'hC3;
        do_start(p, 1'b0);
        for (int s = 1; s <= 3; s++) press(d, bl, bh);
        do_start(8'h00, 1'b0);
        n_checks++;
        if (bit_idx !== 3'd3 || x !== p[4] || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL start_in_shift: got x=%b idx=%0d busy=%b expected x=%b idx=3 busy=1", x, bit_idx, busy, p[4]);
        end
        for (int s = 4; s < 8; s++) begin
            press(d, bl, bh);
            n_checks++;
            if (x !== p[7-s] || bit_idx !== 3'(s)) begin
                n_errors++;
                $display("FAIL ignored_start_step%0d: got x=%b idx=%0d expected x=%b idx=%0d", s, x, bit_idx, p[7-s], s);
            end
        end
        press(d, bl, bh);
        n_checks++;
        if (d != 1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL ignored_start_end: got done_cycles=%0d busy=%b expected 1 0", d, busy);
        end
    endtask

    task automatic test_reset_mid();
        int d, bl, bh, dsum;
        do_start(8'h5A, 1'b0);
        for (int s = 1; s <= 5; s++) press(d, bl, bh);
        n_checks++;
        if (bit_idx !== 3'd5) begin
            n_errors++;
            $display("FAIL pre_reset_idx: got %0d expected 5", bit_idx);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dsum = done ? 1 : 0;
        n_checks++;
        if (x !== 1'b0 || busy !== 1'b0 || bit_idx !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_mid: got x=%b busy=%b idx=%0d expected 0 0 0", x, busy, bit_idx);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) dsum++;
        end
        n_checks++;
        if (dsum != 0) begin
            n_errors++;
            $display("FAIL reset_mid_done: got %0d done cycles expected 0", dsum);
        end
        do_start(8'h81, 1'b0);
        press(d, bl, bh);
        n_checks++;
        if (x !== 1'b0 || bit_idx !== 3'd1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL restart_after_reset: got x=%b idx=%0d busy=%b expected 0 1 1", x, bit_idx, busy);
        end
        do_reset(1);
    endtask

`ifdef SEQ_DEBOUNCE_EN
    task automatic test_debounce();
        int first, changes;
        logic [2:0] prev;
        do_start(8'hF0, 1'b0);
        anjian = 1'b1;
        repeat (10) tick();
        anjian = 1'b0;
        repeat (30) tick();
        n_checks++;
        if (bit_idx !== 3'd0) begin
            n_errors++;
            $display("FAIL glitch_filtered: got idx=%0d expected 0", bit_idx);
        end
        // Step fires 3+16 edges after the rise; x/bit_idx follow one edge later.
        first = 0; changes = 0; prev = bit_idx;
        anjian = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 20) anjian = 1'b0;
            if (bit_idx !== prev) begin
                changes++;
                if (first == 0) first = k;
                prev = bit_idx;
            end
        end
        n_checks++;
        if (changes != 1 || first != 20 || bit_idx !== 3'd1) begin
            n_errors++;
            $display("FAIL debounce_press: got changes=%0d at_edge=%0d idx=%0d expected 1 20 1", changes, first, bit_idx);
        end
        do_reset(1);
    endtask
`endif

    initial begin
        reset = 1'b1; anjian = 1'b0; start = 1'b0; pattern = 8'h00; loop = 1'b0;
        test_reset();
        test_basic_shift();
        test_loop();
        test_ignored_start();
        test_reset_mid();
`ifdef SEQ_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
